mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Round-robin arbiter and scheduler that shares one pipelined `mult` instance among `NREQ` requesters in the FFT datapath. It accepts at most one operand pair per cycle and drives the registered operands into the multiplier. It tracks each issued operation's requester ID through a tag pipeline matched to the multiplier latency, then routes the product back with a one-hot valid. The multiplier has no stall, so the block has no result back-pressure; requesters must always accept results.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: requester ID width; must satisfy 2^ID_W >= NREQ.
- `SIZE_A`, 16: operand A width (signed).
- `SIZE_B`, 8: operand B width (signed).
- `MULT_LAT`, 2: cycles from `mul_a`/`mul_b` to `mul_product` in the attached multiplier. Equals its `PIPE_LEVEL`+1.
- `CNT_W`, 4: in-flight counter width; must hold `MULT_LAT`+1.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: clock, rising edge.
  - `rst` in 1: synchronous reset, active-high.
- Request side:
  - `req` in NREQ: per-requester request. Held high with operands stable until granted.
  - `a_in` in NREQ*SIZE_A: flattened operand A. Requester i occupies bits [i*SIZE_A +: SIZE_A].
  - `b_in` in NREQ*SIZE_B: flattened operand B, same packing.
  - `gnt` out NREQ: combinational one-hot grant. Transfer occurs on a rising edge where `req[i] & gnt[i]`.
- Multiplier side:
  - `mul_a` out SIZE_A: registered operand A to the multiplier.
  - `mul_b` out SIZE_B: registered operand B to the multiplier.
  - `mul_product` in SIZE_A+SIZE_B: multiplier output.
- Result side:
  - `res_data` out SIZE_A+SIZE_B: product; equals `mul_product` passed through combinationally.
  - `res_vld` out NREQ: one-hot result valid for the owning requester.
  - `res_id` out ID_W: binary ID of the owning requester. Meaningful only when `res_vld` != 0.
- Status:
  - `inflight` out CNT_W: count of issued, not-yet-returned operations.
  - `idle` out 1: high when `inflight`==0 and `req`==0.

## Operation
- Arbitration:
  - Round-robin with a last-grant pointer `ptr`. The search starts at `ptr`+1 mod NREQ; the first asserted `req` wins.
  - `gnt` is zero when `req`==0 or during `rst`.
  - On a transfer, `ptr` updates to the winner; otherwise `ptr` holds.
- Issue stage (registered):
  - On a transfer, `mul_a`/`mul_b` load the winner's operands.
  - Otherwise they load 0, so the idle multiplier computes 0 and does not toggle.
- Tag pipeline:
  - `1+MULT_LAT` stages, each holding {valid, ID}.
  - Stage 0 loads {transfer, winner ID}; each later stage shifts from the previous one.
  - The last stage drives `res_vld` (one-hot decode of ID, gated by valid) and `res_id`.
- In-flight counter:
  - +1 on a transfer, -1 when the last tag stage is valid, net 0 when both occur.
  - Never wraps; CNT_W sizing guarantees this.
- Arithmetic: the block does no arithmetic on data. Widths pass unchanged, signed.
- Reset (a synchronous `rst` pulse, including mid-operation):
  - `ptr`=NREQ-1, so requester 0 has first priority.
  - All tag valids=0, `mul_a`=0, `mul_b`=0, `inflight`=0.
  - Products still draining from the multiplier (which has no reset) are discarded: `res_vld` stays 0 for them.
- Output values during and right after reset: `gnt`=0, `res_vld`=0, `res_id`=0, `idle`=1 (unless `req` is high).

## Timing
- Latency from a transfer edge T to `res_vld` is exactly 1+MULT_LAT cycles:
  - at edge T, the operands register into `mul_a`/`mul_b`;
  - the product appears MULT_LAT cycles after that;
  - `res_vld` is high in the cycle after edge T+MULT_LAT. With the default, that is the 3rd cycle after transfer.
- Throughput is one operation per cycle, fully pipelined. Back-to-back grants to different or the same requester are legal.
- A requester holding `req` continuously under full contention is granted at least once every NREQ cycles.
- Results return in issue order. At most one `res_vld` bit is high per cycle.
- `gnt` depends combinationally on `req` and `ptr` only, never on operands.

## Test plan
- Single request: `req`=0001, `a_in[0]`=300, `b_in[0]`=-5, grant at cycle 0. Required: `gnt`=0001 at cycle 0; `res_vld`=0001 with `res_data`=-1500 and `res_id`=0 exactly 3 cycles later (MULT_LAT=2); `inflight` goes 1 then 0.
- Full contention: `req`=1111 held for 8 cycles after reset, each requester i supplying a=i+1, b=2. Required: grant order 0,1,2,3,0,1,2,3; results 2,4,6,8,2,4,6,8 in that order, each with matching `res_vld`/`res_id`.
- Pointer fairness: `req`=0101 after the last grant went to requester 0. Required: the next grant goes to 2, then 0, alternating.
- Simultaneous issue and retire: a continuous stream to requester 1. Required: `inflight` holds steady at 3 (=1+MULT_LAT) in steady state; `idle`=0; `idle`=1 one cycle after the last result returns with `req`=0.
- Extreme values: a=-32768, b=-128. Required: `res_data`=4194304 with correct sign, no truncation at width 24.
- Reset mid-flight: three operations issued, then `rst` asserted for 1 cycle before any return. Required: no `res_vld` pulse for those three; `inflight`=0; the next grant goes to requester 0 when `req`=1111.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one pipelined multiplier among NREQ requesters.
// Registered operands feed the multiplier; a tag pipeline matched to the
// multiplier latency routes each product back to the requester that issued it.
module mult_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned SIZE_A   = 16,
    parameter int unsigned SIZE_B   = 8,
    parameter int unsigned MULT_LAT = 2,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*SIZE_A-1:0]     a_in,
    input  logic [NREQ*SIZE_B-1:0]     b_in,
    output logic [NREQ-1:0]            gnt,
    output logic [SIZE_A-1:0]          mul_a,
    output logic [SIZE_B-1:0]          mul_b,
    input  logic [SIZE_A+SIZE_B-1:0]   mul_product,
    output logic [SIZE_A+SIZE_B-1:0]   res_data,
    output logic [NREQ-1:0]            res_vld,
    output logic [ID_W-1:0]            res_id,
    output logic [CNT_W-1:0]           inflight,
    output logic                       idle
);

    localparam int unsigned NSTG = MULT_LAT + 1;

    logic [ID_W-1:0]            ptr_q, ptr_d;
    logic [SIZE_A-1:0]          mul_a_q, mul_a_d;
    logic [SIZE_B-1:0]          mul_b_q, mul_b_d;
    logic [NSTG-1:0]            vld_q, vld_d;
    logic [NSTG-1:0][ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0]           inflight_q, inflight_d;

    logic [NREQ-1:0]            gnt_c;
    logic [ID_W-1:0]            win_id;
    logic [ID_W-1:0]            idx;
    logic                       found;
    logic                       xfer;
    logic                       retire;
    logic [SIZE_A-1:0]          a_sel;
    logic [SIZE_B-1:0]          b_sel;

    // Round-robin search starting just after the last winner; depends on req and ptr only.
    always_comb begin
        gnt_c  = '0;
        win_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = ID_W'((32'(ptr_q) + k) % NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt_c[idx] = 1'b1;
                win_id     = idx;
            end
        end
        if (rst) begin
            gnt_c = '0;
        end
    end

    assign gnt    = gnt_c;
    assign xfer   = |gnt_c;
    assign retire = vld_q[NSTG-1];

    // Operand mux driven by the one-hot grant, zero when nothing is granted.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_c[i]) begin
                a_sel = a_in[i*SIZE_A +: SIZE_A];
                b_sel = b_in[i*SIZE_B +: SIZE_B];
            end
        end
    end

    // Next-state: pointer, issue registers, tag shift and in-flight count.
    always_comb begin
        ptr_d   = xfer ? win_id : ptr_q;
        mul_a_d = a_sel;
        mul_b_d = b_sel;
        vld_d   = {vld_q[NSTG-2:0], xfer};
        id_d    = id_q;
        id_d[0] = xfer ? win_id : '0;
        for (int s = 1; s < int'(NSTG); s++) begin
            id_d[s] = id_q[s-1];
        end
        unique case ({xfer, retire})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers with synchronous reset; requester 0 gets first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= ID_W'(NREQ - 1);
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            vld_q      <= '0;
            id_q       <= '0;
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            vld_q      <= vld_d;
            id_q       <= id_d;
            inflight_q <= inflight_d;
        end
    end

    // Result routing; masked during reset so draining products are dropped.
    always_comb begin
        res_vld = '0;
        res_id  = '0;
        if (retire && !rst) begin
            res_id = id_q[NSTG-1];
            for (int i = 0; i < int'(NREQ); i++) begin
                res_vld[i] = (id_q[NSTG-1] == ID_W'(i));
            end
        end
    end

    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign res_data = mul_product;
    assign inflight = inflight_q;
    assign idle     = (rst || (inflight_q == '0)) && (req == '0);

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural 2-stage multiplier and a
// result scoreboard keyed on expected requester, product and return cycle.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  gnt;
    logic [15:0] mul_a;
    logic [7:0]  mul_b;
    logic [23:0] mul_product;
    logic [23:0] res_data;
    logic [3:0]  res_vld;
    logic [1:0]  res_id;
    logic [3:0]  inflight;
    logic        idle;

    logic signed [15:0] a_v [4];
    logic signed [7:0]  b_v [4];

    typedef struct {
        logic [1:0]  id;
        logic [23:0] data;
        int          cyc;
    } exp_t;

    exp_t sb [$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic [23:0] p_pipe [2];

    mult_arbiter #(
        .NREQ(4), .ID_W(2), .SIZE_A(16), .SIZE_B(8), .MULT_LAT(2), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
        .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
        .res_data(res_data), .res_vld(res_vld), .res_id(res_id),
        .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] prod(input logic signed [15:0] a, input logic signed [7:0] b);
        int p;
        p = a * b;
        return p[23:0];
    endfunction

    // External multiplier: product appears two edges after mul_a/mul_b.
    always @(posedge clk) begin
        p_pipe[0] <= prod(mul_a, mul_b);
        p_pipe[1] <= p_pipe[0];
    end
    assign mul_product = p_pipe[1];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_in[i*16 +: 16] = a_v[i];
            b_in[i*8 +: 8]   = b_v[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check grant at the falling edge; queue the expected result of a transfer.
    task automatic arb(input logic [3:0] exp_gnt, input bit push);
        exp_t x;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        if (push && exp_gnt != 4'b0) begin
            for (int i = 0; i < 4; i++) begin
                if (exp_gnt[i]) begin
                    x.id   = 2'(i);
                    x.data = prod(a_v[i], b_v[i]);
                end
            end
            x.cyc = cyc + 3;
            sb.push_back(x);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            arb(4'b0000, 0);
            tick();
        end
    endtask

    // Scoreboard pop on every returned result.
    always @(negedge clk) begin
        if (res_vld !== 4'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_res_vld", 32'(res_vld), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("res_vld", 32'(res_vld), 32'(1) << e.id);
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_data", 32'(res_data), 32'(e.data));
                chk("res_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end

        // Reset behaviour
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_res_vld", 32'(res_vld), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        tick();
        tick();
        @(negedge clk);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        rst = 1'b0;
        req = 4'b0000;
        tick();
        @(negedge clk);
        chk("post_rst_idle", 32'(idle), 32'd1);
        chk("post_rst_gnt", 32'(gnt), 32'd0);
        tick();

        // Single request
        req = 4'b0001; a_v[0] = 16'sd300; b_v[0] = -8'sd5;
        arb(4'b0001, 1);
        tick();
        req = 4'b0000;
        arb(4'b0000, 0);
        chk("single_inflight1", 32'(inflight), 32'd1);
        chk("single_mul_a", 32'(mul_a), 32'd300);
        chk("single_mul_b", 32'(mul_b), 32'h0000_00FB);
        tick();
        drain(1);
        arb(4'b0000, 0);
        chk("single_inflight_ret", 32'(inflight), 32'd1);
        tick();
        arb(4'b0000, 0);
        chk("single_inflight0", 32'(inflight), 32'd0);
        chk("single_idle", 32'(idle), 32'd1);
        tick();

        // Full contention after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = 16'(i + 1);
            b_v[i] = 8'sd2;
        end
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            arb(4'b0001 << (k % 4), 1);
            tick();
        end
        req = 4'b0000;
        drain(4);

        // Pointer fairness: last grant to 0, then 0101 alternates 2,0
        req = 4'b0001; a_v[0] = 16'sd7; b_v[0] = -8'sd3;
        arb(4'b0001, 1);
        tick();
        req = 4'b0101; a_v[2] = -16'sd100; b_v[2] = 8'sd9;
        arb(4'b0100, 1); tick();
        arb(4'b0001, 1); tick();
        arb(4'b0100, 1); tick();
        arb(4'b0001, 1); tick();
        req = 4'b0000;
        drain(4);

        // Continuous stream to requester 1
        req = 4'b0010; a_v[1] = 16'sd11; b_v[1] = 8'sd13;
        for (int k = 0; k < 6; k++) begin
            arb(4'b0010, 1);
            if (k >= 3) begin
                chk("stream_inflight", 32'(inflight), 32'd3);
                chk("stream_idle", 32'(idle), 32'd0);
            end
            tick();
        end
        req = 4'b0000;
        arb(4'b0000, 0);
        chk("tail_inflight3", 32'(inflight), 32'd3);
        tick();
        arb(4'b0000, 0);
        chk("tail_inflight2", 32'(inflight), 32'd2);
        tick();
        arb(4'b0000, 0);
        chk("tail_idle_last", 32'(idle), 32'd0);
        tick();
        arb(4'b0000, 0);
        chk("tail_inflight0", 32'(inflight), 32'd0);
        chk("tail_idle", 32'(idle), 32'd1);
        tick();

        // Extreme operands
        req = 4'b0001; a_v[0] = -16'sd32768; b_v[0] = -8'sd128;
        arb(4'b0001, 1);
        tick();
        req = 4'b0000;
        arb(4'b0000, 0);
        chk("ext_mul_a", 32'(mul_a), 32'h0000_8000);
        chk("ext_mul_b", 32'(mul_b), 32'h0000_0080);
        tick();
        drain(4);

        // Reset with three operations in flight: none may return
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = 16'(100 + i);
            b_v[i] = 8'sd5;
        end
        arb(4'b0010, 0); tick();
        arb(4'b0100, 0); tick();
        arb(4'b1000, 0); tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_res_vld", 32'(res_vld), 32'd0);
        tick();
        rst = 1'b0;
        arb(4'b0001, 1);
        chk("midrst_inflight", 32'(inflight), 32'd0);
        tick();
        req = 4'b0000;
        drain(5);

        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("final_idle", 32'(idle), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
